// File: rtl/freq_generator.sv
// freq_generator: programmable 50%-duty square-wave source.
// A 16-bit frequency request (Hz) is turned into a half-period count by an
// iterative restoring divider (CLK_HZ/2 / freq, one quotient bit per clock),
// and a RUN counter then toggles OUT every q clocks.
// Optional build macro: FREQ_GEN_PHASE_ALIGN_EN -- when defined, OUT is forced
// low on entry to RUN so every new program starts with a full low half-period.
module freq_generator #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int          FREQ_W = 16,
  parameter int          CNT_W  = 26
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FREQ_W-1:0] freq,
  input  logic              load,
  output logic              OUT,
  output logic              busy,
  output logic              active
);

  // Controller states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // Constant dividend: half the clock rate gives the half-period in clocks
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ / 2);
  localparam int               STEP_W   = $clog2(CNT_W + 1);

  logic [1:0]        state_q,   state_d;
  logic [FREQ_W-1:0] divisor_q, divisor_d;
  logic [FREQ_W-1:0] rem_q,     rem_d;
  logic [CNT_W-1:0]  dvd_q,     dvd_d;
  logic [CNT_W-1:0]  quo_q,     quo_d;
  logic [STEP_W-1:0] step_q,    step_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              out_q,     out_d;
  logic              busy_q,    busy_d;
  logic              active_q,  active_d;

  // Divider datapath signals
  logic [FREQ_W:0]   rem_shift;
  logic [FREQ_W:0]   rem_diff;
  logic              q_bit;
  logic [FREQ_W-1:0] rem_step;
  logic [CNT_W-1:0]  quo_step;
  logic [CNT_W-1:0]  q_final;
  logic              last_step;
  logic              term_cnt;
  logic              load_ok;

  // One restoring-division step: bring down the next dividend bit, try to
  // subtract the divisor, keep the difference when it did not borrow.
  // The remainder is always below the divisor, so the shifted value is below
  // twice the divisor and the MSB of the difference is a clean borrow flag.
  always_comb begin
    rem_shift = {rem_q, dvd_q[CNT_W-1]};
    rem_diff  = rem_shift - {1'b0, divisor_q};
    q_bit     = ~rem_diff[FREQ_W];
    rem_step  = q_bit ? rem_diff[FREQ_W-1:0] : rem_shift[FREQ_W-1:0];
    quo_step  = {quo_q[CNT_W-2:0], q_bit};
    // Requests above CLK_HZ/2 would give a zero half-period; clamp to one clock
    q_final   = (quo_step == '0) ? CNT_W'(1) : quo_step;
    last_step = (step_q == STEP_W'(1));
    term_cnt  = (cnt_q == (quo_q - CNT_W'(1)));
    load_ok   = load & ~busy_q;
  end

  // Next-state logic for the controller, divider and half-period counter
  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    busy_d    = busy_q;
    active_d  = active_q;

    case (state_q)
      ST_DIVIDE: begin
        rem_d  = rem_step;
        quo_d  = quo_step;
        dvd_d  = {dvd_q[CNT_W-2:0], 1'b0};
        step_d = step_q - STEP_W'(1);
        if (last_step) begin
          state_d  = ST_RUN;
          quo_d    = q_final;
          cnt_d    = '0;
          busy_d   = 1'b0;
          active_d = 1'b1;
`ifdef FREQ_GEN_PHASE_ALIGN_EN
          out_d    = 1'b0;
`else
          out_d    = out_q;
`endif
        end
      end
      ST_RUN: begin
        if (term_cnt) begin
          cnt_d = '0;
          out_d = ~out_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE: OUT holds, nothing counts
      end
    endcase

    // An accepted load overrides everything above, including a toggle that
    // would have happened on this same cycle.
    if (load_ok) begin
      if (freq != '0) begin
        state_d   = ST_DIVIDE;
        divisor_d = freq;
        rem_d     = '0;
        quo_d     = '0;
        dvd_d     = DIVIDEND;
        step_d    = STEP_W'(CNT_W);
        cnt_d     = '0;
        out_d     = out_q;
        busy_d    = 1'b1;
        active_d  = 1'b0;
      end else begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        out_d     = 1'b0;
        busy_d    = 1'b0;
        active_d  = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset to the idle, all-zero condition
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      divisor_q <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      quo_q     <= quo_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      active_q  <= active_d;
    end
  end

  assign OUT    = out_q;
  assign busy   = busy_q;
  assign active = active_q;

endmodule

// File: tb/tb_freq_generator.sv
// Testbench for freq_generator: scoreboard of expected output transitions
// (OUT/busy/active) built from the frequency rules, checked by a monitor.
module tb_freq_generator;

  localparam int unsigned CLK_HZ  = 2000000;
  localparam int unsigned HALF    = CLK_HZ / 2;
  localparam int unsigned CLK_HZ2 = 1000;
  localparam int          FREQ_W  = 16;
  localparam int          CNT_W   = 26;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FREQ_W-1:0] freq = '0;
  logic              load = 1'b0;
  logic              out, busy, active;
  logic [FREQ_W-1:0] freq2 = '0;
  logic              load2 = 1'b0;
  logic              out2, busy2, active2;

  freq_generator #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .freq(freq), .load(load),
    .OUT(out), .busy(busy), .active(active)
  );

  freq_generator #(.CLK_HZ(CLK_HZ2), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut_small (
    .CLK(clk), .RST(rst), .freq(freq2), .load(load2),
    .OUT(out2), .busy(busy2), .active(active2)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic o;
    logic b;
    logic a;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic m_o = 1'b0, m_b = 1'b0, m_a = 1'b0;
  bit   mon_en = 1'b0;

  // Record an expected output transition, only when the tuple actually changes
  function automatic void push_ev(input int t, input logic o, input logic b, input logic a);
    ev_t e;
    if ({o, b, a} != {m_o, m_b, m_a}) begin
      e.cyc = t; e.o = o; e.b = b; e.a = a;
      exp_q.push_back(e);
      m_o = o; m_b = b; m_a = a;
    end
  endfunction

  function automatic int half_period(input int unsigned half, input int unsigned f);
    int unsigned q;
    q = half / f;
    if (q == 0) q = 1;
    return int'(q);
  endfunction

  // Monitor: every observed change of (OUT,busy,active) must match the next expected one
  initial begin : monitor
    logic p_o, p_b, p_a;
    ev_t  e;
    p_o = 1'b0; p_b = 1'b0; p_a = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && ({out, busy, active} !== {p_o, p_b, p_a})) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got out=%b busy=%b active=%b required no change",
                   cyc, out, busy, active);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.o !== out || e.b !== busy || e.a !== active) begin
            errors++;
            $display("FAIL event got cyc=%0d out=%b busy=%b active=%b required cyc=%0d out=%b busy=%b active=%b",
                     cyc, out, busy, active, e.cyc, e.o, e.b, e.a);
          end
        end
      end
      p_o = out; p_b = busy; p_a = active;
    end
  end

  // Issue a load of f, then hold for w cycles (next load is sampled w edges later).
  // poke>0 pulses an extra load with random freq that many cycles in (during the divide).
  task automatic prog(input logic [FREQ_W-1:0] f, input int w, input int poke);
    int   e, q, t;
    logic o;
    load = 1'b1;
    freq = f;
    e    = cyc + 1;
    q    = 0;
    if (f == '0) begin
      push_ev(e, 1'b0, 1'b0, 1'b0);
    end else begin
      q = half_period(HALF, f);
      push_ev(e, m_o, 1'b1, 1'b0);
      if (w > CNT_W) begin
`ifdef FREQ_GEN_PHASE_ALIGN_EN
        o = 1'b0;
`else
        o = m_o;
`endif
        push_ev(e + CNT_W, o, 1'b0, 1'b1);
        t = e + CNT_W + q;
        while (t < e + w) begin
          o = ~o;
          push_ev(t, o, 1'b0, 1'b1);
          t += q;
        end
      end
    end
    $display("prog freq=%0d q=%0d window=%0d poke=%0d start_cyc=%0d", f, q, w, poke, e);
    for (int i = 1; i <= w; i++) begin
      @(negedge clk); #1;
      if (i == 1) load = 1'b0;
      if (poke > 0 && i == poke) begin
        load = 1'b1;
        freq = FREQ_W'($urandom);
      end
      if (poke > 0 && i == poke + 1) load = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events freq=%0d got pending=%0d required 0 (next expected cyc=%0d)",
               f, exp_q.size(), exp_q[0].cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", name, got, req);
    end
  endtask

  // Assert reset asynchronously between clock edges and check outputs clear at once
  task automatic async_reset(input string tag);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check_bit({tag, "_out"},    out,    1'b0);
    check_bit({tag, "_busy"},   busy,   1'b0);
    check_bit({tag, "_active"}, active, 1'b0);
    $display("async reset %s at cyc=%0d", tag, cyc);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_o = 1'b0; m_b = 1'b0; m_a = 1'b0;
    @(negedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin : stim
    int unsigned f;
    int q, w, poke, e2, q2;
    logic o0, expo;

    repeat (3) @(negedge clk);
    #1;
    check_bit("reset_out",    out,    1'b0);
    check_bit("reset_busy",   busy,   1'b0);
    check_bit("reset_active", active, 1'b0);
    check_bit("reset_out2",   out2,   1'b0);
    rst = 1'b0;
    @(negedge clk); #1;
    mon_en = 1'b1;

    // Directed programs
    prog(16'd50,    CNT_W + 20000 + 5, 0);
    prog(16'd1000,  CNT_W + 4 * 1000 + 10, 0);
    prog(16'd65535, CNT_W + 15 * 6 + 3, 5);       // ignored load during divide
    prog(16'd0,     10000, 0);                    // OUT stays low
    prog(16'd1000,  CNT_W + 3 * 1000, 0);         // next load lands on a terminal count
    prog(16'd2000,  CNT_W + 500 * 3 + 7, 3);      // reload from RUN, poke while busy
    prog(16'd65535, CNT_W + 1, 0);                // shortest accepted window

    // Randomized programs
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        prog(16'd0, int'($urandom_range(1, 200)), 0);
      end else begin
        f    = $urandom_range(2000, 65535);
        q    = half_period(HALF, f);
        w    = CNT_W + 1 + int'($urandom_range(0, 4 * q));
        poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, CNT_W - 1)) : 0;
        prog(FREQ_W'(f), w, poke);
      end
    end

    // Reset in the middle of a divide, then in the middle of a run with OUT high
    prog(16'd1000, 10, 0);
    async_reset("mid_divide");
    prog(16'd65535, CNT_W + 18, 0);
    check_bit("pre_reset_out_high", out, 1'b1);
    async_reset("mid_run");

    // Small-clock instance: request far above CLK_HZ/2, half-period clamps to one clock
    q2 = half_period(CLK_HZ2 / 2, 65535);
    load2 = 1'b1; freq2 = 16'd65535;
    e2 = cyc + 1;
    @(negedge clk); #1;
    load2 = 1'b0;
    while (cyc < e2 + CNT_W) begin
      @(negedge clk); #1;
    end
    check_bit("clamp_active", active2, 1'b1);
    check_bit("clamp_busy",   busy2,   1'b0);
    o0 = out2;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      expo = o0 ^ logic'((i / q2) % 2);
      check_bit("clamp_toggle", out2, expo);
    end
    $display("clamp instance q=%0d checked 8 cycles", q2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
